// File: rtl/acc_diag_reader_pkg.sv
// Shared types and step helpers for the accumulator read sequencer.
// Helpers are pure combinational; the column/step geometry lives only here.
// No flow control of its own.
package acc_diag_reader_pkg;

  localparam int N_COLS    = 32;
  localparam int ADDR_W    = 7;
  localparam int ACC_DEPTH = 128;
  localparam int RES_W     = 32;

  typedef logic [RES_W-1:0] res_t;

  typedef enum logic {
    ACC_RD_NORMAL = 1'b0,
    ACC_RD_DIAG   = 1'b1
  } acc_rd_mode;

  typedef struct packed {
    acc_rd_mode          mode;
    logic [ADDR_W-1:0]   base;
    logic [ADDR_W:0]     rows;
  } acc_rd_cmd_t;

  // Index of the final step: DIAG needs N_COLS-1 extra steps to finish the skew.
  function automatic logic [ADDR_W:0] last_step(input acc_rd_cmd_t cmd);
    if (cmd.mode == ACC_RD_DIAG)
      return cmd.rows + (ADDR_W+1)'(N_COLS - 2);
    return cmd.rows - (ADDR_W+1)'(1);
  endfunction

  function automatic logic col_active(input acc_rd_cmd_t cmd, input logic [ADDR_W:0] t, input int c);
    logic [ADDR_W:0] cw;
    cw = (ADDR_W+1)'(c);
    if (cmd.mode == ACC_RD_NORMAL)
      return 1'b1;
    return (t >= cw) && ((t - cw) < cmd.rows);
  endfunction

  function automatic logic [ADDR_W-1:0] col_addr(input acc_rd_cmd_t cmd, input logic [ADDR_W:0] t, input int c);
    if (cmd.mode == ACC_RD_NORMAL)
      return cmd.base + t[ADDR_W-1:0];
    return cmd.base + t[ADDR_W-1:0] - ADDR_W'(c);
  endfunction

endpackage

// File: rtl/acc_diag_reader_skid.sv
// Two-entry fall-through valid/ready buffer for {mask, data} beats.
// Latency: 0 cycles when empty and downstream ready, else FIFO order.
// Backpressure: no in_rdy; the writer must hold a credit, pushes are never refused.
module acc_rd_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q, rd_ptr_q;
  logic [1:0]   cnt_q;
  logic         wr, rd;

  assign out_vld = (cnt_q != 2'd0) || in_vld;
  assign out_dat = (cnt_q != 2'd0) ? mem_q[rd_ptr_q] : in_dat;
  // Incoming beat only lands in storage when it cannot leave straight away.
  assign wr      = in_vld && !((cnt_q == 2'd0) && out_rdy);
  assign rd      = out_vld && out_rdy && (cnt_q != 2'd0);
  assign count   = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (wr) wr_ptr_q <= ~wr_ptr_q;
      if (rd) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + 2'(wr) - 2'(rd);
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= in_dat;
  end

endmodule

// File: rtl/acc_diag_reader.sv
// Accumulator-bank read sequencer: row-aligned or diagonally skewed beats.
// Latency: first beat valid 2 cycles after start (issue + bank read).
// Backpressure: reads issued only against free skid slots; beats held while out_ready_i low.
module acc_diag_reader
  import acc_diag_reader_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start_i,
  input  acc_rd_mode                     mode_i,
  input  logic [ADDR_W-1:0]              base_addr_i,
  input  logic [ADDR_W:0]                num_rows_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [N_COLS-1:0]              acc_rd_en_o,
  output logic [N_COLS-1:0][ADDR_W-1:0]  acc_rd_addr_o,
  input  res_t [N_COLS-1:0]              acc_rd_data_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output res_t [N_COLS-1:0]              out_data_o,
  output logic [N_COLS-1:0]              out_mask_o
);

  localparam int PW = N_COLS + N_COLS * RES_W;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN} state_t;

  state_t                          state_q;
  acc_rd_cmd_t                     cmd_q, cmd_in, step_cmd;
  logic [ADDR_W:0]                 t_q, step_t;
  logic                            rd_vld_q, pipe_vld_q;
  logic [N_COLS-1:0]               pipe_mask_q, nxt_en;
  logic [N_COLS-1:0][ADDR_W-1:0]   nxt_addr;
  res_t [N_COLS-1:0]               in_data, skid_data;
  logic [N_COLS-1:0]               skid_mask;
  logic [PW-1:0]                   skid_in, skid_out;
  logic [1:0]                      skid_cnt;
  logic [2:0]                      occ_after;
  logic                            skid_vld, pop, credit;

  assign cmd_in = {mode_i, base_addr_i, num_rows_i};

  // Step 0 is issued on the start edge itself, so it is computed from the inputs.
  always_comb begin
    step_cmd = busy_o ? cmd_q : cmd_in;
    step_t   = busy_o ? t_q : '0;
    nxt_en   = '0;
    nxt_addr = '0;
    for (int c = 0; c < N_COLS; c++) begin
      nxt_en[c]   = col_active(step_cmd, step_t, c);
      nxt_addr[c] = nxt_en[c] ? col_addr(step_cmd, step_t, c) : '0;
    end
  end

  assign pop       = skid_vld && out_ready_i;
  assign occ_after = 3'(skid_cnt) + 3'(pipe_vld_q) - 3'(pop);
  // The read being issued lands two cycles out; count everything already headed for the buffer.
  assign credit    = (occ_after + 3'(rd_vld_q)) < 3'd2;

  always_comb begin
    in_data = '0;
    for (int c = 0; c < N_COLS; c++)
      in_data[c] = pipe_mask_q[c] ? acc_rd_data_i[c] : '0;
  end

  assign skid_in = {pipe_mask_q, in_data};

  acc_rd_skid #(.W(PW)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (pipe_vld_q),
    .in_dat  (skid_in),
    .out_vld (skid_vld),
    .out_rdy (out_ready_i),
    .out_dat (skid_out),
    .count   (skid_cnt)
  );

  assign {skid_mask, skid_data} = skid_out;
  assign out_valid_o = skid_vld;
  assign out_mask_o  = skid_vld ? skid_mask : '0;
  assign out_data_o  = skid_vld ? skid_data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cmd_q         <= '0;
      t_q           <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      acc_rd_en_o   <= '0;
      acc_rd_addr_o <= '0;
      rd_vld_q      <= 1'b0;
      pipe_vld_q    <= 1'b0;
      pipe_mask_q   <= '0;
    end else begin
      rd_vld_q    <= 1'b0;
      acc_rd_en_o <= '0;
      done_o      <= 1'b0;
      pipe_vld_q  <= rd_vld_q;
      pipe_mask_q <= acc_rd_en_o;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            cmd_q  <= cmd_in;
            busy_o <= 1'b1;
            t_q    <= (ADDR_W+1)'(1);
            if (num_rows_i == '0) begin
              state_q <= ST_DRAIN;
            end else begin
              acc_rd_en_o   <= nxt_en;
              acc_rd_addr_o <= nxt_addr;
              rd_vld_q      <= 1'b1;
              state_q       <= (last_step(cmd_in) == '0) ? ST_DRAIN : ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (credit) begin
            acc_rd_en_o   <= nxt_en;
            acc_rd_addr_o <= nxt_addr;
            rd_vld_q      <= 1'b1;
            t_q           <= t_q + (ADDR_W+1)'(1);
            if (t_q == last_step(cmd_q)) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!rd_vld_q && occ_after == 3'd0) begin
            state_q <= ST_IDLE;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_diag_reader.sv
// Scoreboard bench for acc_diag_reader with a behavioural accumulator-bank model.
module tb_acc_diag_reader;
  import acc_diag_reader_pkg::*;

  typedef struct packed {
    logic [N_COLS-1:0]        mask;
    logic [N_COLS-1:0][31:0]  data;
  } beat_t;

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic                          start_i;
  acc_rd_mode                    mode_i;
  logic [ADDR_W-1:0]             base_addr_i;
  logic [ADDR_W:0]               num_rows_i;
  logic                          busy_o, done_o;
  logic [N_COLS-1:0]             acc_rd_en_o;
  logic [N_COLS-1:0][ADDR_W-1:0] acc_rd_addr_o;
  res_t [N_COLS-1:0]             acc_rd_data_i;
  logic                          out_valid_o;
  logic                          out_ready_i;
  res_t [N_COLS-1:0]             out_data_o;
  logic [N_COLS-1:0]             out_mask_o;

  beat_t exp_q[$];
  int    n_checks = 0, n_fail = 0;
  int    cyc = 0;
  int    beats = 0, last_hs_cyc = 0, first_vld_cyc = 0;
  bit    first_pending = 0;
  int    issued = 0, popped = 0, max_out = 0;
  bit    held_vld = 0;
  logic [N_COLS-1:0] held_mask;
  res_t [N_COLS-1:0] held_data;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  acc_diag_reader dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start_i),
    .mode_i        (mode_i),
    .base_addr_i   (base_addr_i),
    .num_rows_i    (num_rows_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .acc_rd_en_o   (acc_rd_en_o),
    .acc_rd_addr_o (acc_rd_addr_o),
    .acc_rd_data_i (acc_rd_data_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_data_o    (out_data_o),
    .out_mask_o    (out_mask_o)
  );

  function automatic res_t bank_val(input int c, input int a);
    return 32'hA500_0000 | 32'(c << 16) | 32'(a);
  endfunction

  // Bank model: one-cycle read latency, garbage on unread banks.
  always @(posedge clk) begin
    for (int c = 0; c < N_COLS; c++)
      acc_rd_data_i[c] <= acc_rd_en_o[c] ? bank_val(c, int'(acc_rd_addr_o[c])) : res_t'($urandom);
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push_expected(input acc_rd_mode m, input int base, input int rows);
    int n_steps;
    beat_t b;
    n_steps = (rows == 0) ? 0 : ((m == ACC_RD_NORMAL) ? rows : rows + N_COLS - 1);
    for (int t = 0; t < n_steps; t++) begin
      b = '0;
      for (int c = 0; c < N_COLS; c++) begin
        int k;
        k = (m == ACC_RD_NORMAL) ? t : t - c;
        if (k >= 0 && k < rows) begin
          b.mask[c] = 1'b1;
          b.data[c] = bank_val(c, (base + k) % ACC_DEPTH);
        end
      end
      exp_q.push_back(b);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      held_vld = 0;
    end else begin
      if (|acc_rd_en_o) issued++;
      if (issued - popped > max_out) max_out = issued - popped;
      if (out_valid_o && first_pending) begin
        first_vld_cyc = cyc;
        first_pending = 0;
      end
      if (held_vld) begin
        check("stall_valid", out_valid_o, 1);
        check("stall_mask", out_mask_o, held_mask);
        check("stall_data", out_data_o == held_data, 1);
      end
      if (out_valid_o && out_ready_i) begin
        popped++;
        beats++;
        last_hs_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", out_valid_o, 0);
        end else begin
          beat_t b;
          int fc;
          b  = exp_q.pop_front();
          fc = 0;
          for (int c = N_COLS - 1; c >= 0; c--)
            if (out_data_o[c] !== b.data[c]) fc = c;
          check("beat_mask", out_mask_o, b.mask);
          check($sformatf("beat%0d_data_col%0d", beats - 1, fc), out_data_o[fc], b.data[fc]);
        end
      end
      held_vld  = out_valid_o && !out_ready_i;
      held_mask = out_mask_o;
      held_data = out_data_o;
    end
  end

  task automatic do_start(input acc_rd_mode m, input int base, input int rows, output int s_cyc);
    @(posedge clk); #1;
    push_expected(m, base, rows);
    start_i       = 1'b1;
    mode_i        = m;
    base_addr_i   = ADDR_W'(base);
    num_rows_i    = (ADDR_W+1)'(rows);
    s_cyc         = cyc;
    first_pending = 1;
    beats         = 0;
    max_out       = 0;
    @(posedge clk); #1;
    start_i = 1'b0;
    check("busy_after_start", busy_o, 1);
  endtask

  task automatic wait_done(input int budget, input bit rnd, output int done_cyc);
    done_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (rnd) out_ready_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (done_o) begin
        done_cyc = cyc;
        break;
      end
    end
    if (done_cyc < 0) check("done_timeout", done_o, 1);
    @(posedge clk); #1;
    out_ready_i = 1'b1;
    check("busy_after_done", busy_o, 0);
    check("beats_left", exp_q.size(), 0);
  endtask

  initial begin
    int s, d;
    rst_n       = 1'b0;
    start_i     = 1'b0;
    mode_i      = ACC_RD_NORMAL;
    base_addr_i = '0;
    num_rows_i  = '0;
    out_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_valid", out_valid_o, 0);
    check("rst_rd_en", acc_rd_en_o, 0);
    check("rst_mask", out_mask_o, 0);
    @(negedge clk) rst_n = 1'b1;

    // NORMAL, base 10, 4 rows
    do_start(ACC_RD_NORMAL, 10, 4, s);
    wait_done(200, 0, d);
    check("normal_first_latency", first_vld_cyc - s, 2);
    check("normal_done_gap", d - last_hs_cyc, 1);
    check("normal_beats", beats, 4);

    // DIAG, base 0, 2 rows
    do_start(ACC_RD_DIAG, 0, 2, s);
    wait_done(200, 0, d);
    check("diag_first_latency", first_vld_cyc - s, 2);
    check("diag_beats", beats, 33);

    // address wrap
    do_start(ACC_RD_NORMAL, 126, 4, s);
    wait_done(200, 0, d);
    check("wrap_beats", beats, 4);

    // mid-stream stall of 5 cycles
    do_start(ACC_RD_DIAG, 50, 8, s);
    for (int i = 0; i < 100 && beats < 4; i++) @(negedge clk);
    @(posedge clk); #1;
    out_ready_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    out_ready_i = 1'b1;
    wait_done(300, 0, d);
    check("stall_beats", beats, 39);
    check("stall_inflight_le2", max_out <= 2, 1);

    // random backpressure across the address wrap
    do_start(ACC_RD_DIAG, 120, 5, s);
    wait_done(400, 1, d);
    check("rand_beats", beats, 36);
    check("rand_inflight_le2", max_out <= 2, 1);

    // start pulsed while busy must be ignored
    do_start(ACC_RD_NORMAL, 40, 6, s);
    start_i     = 1'b1;
    mode_i      = ACC_RD_DIAG;
    base_addr_i = '0;
    num_rows_i  = 8'd3;
    @(posedge clk); #1;
    start_i = 1'b0;
    check("ignored_start_busy", busy_o, 1);
    wait_done(200, 0, d);
    check("ignored_start_beats", beats, 6);

    // zero rows: done pulse only
    do_start(ACC_RD_NORMAL, 5, 0, s);
    wait_done(50, 0, d);
    check("zero_rows_beats", beats, 0);
    check("zero_rows_done_seen", d >= 0, 1);

    // reset in the middle of a DIAG transfer
    do_start(ACC_RD_DIAG, 0, 2, s);
    for (int i = 0; i < 200 && beats < 10; i++) begin
      @(negedge clk); #1;
    end
    check("reset_reached_beat10", beats, 10);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid_o, 0);
    check("mid_rst_mask", out_mask_o, 0);
    check("mid_rst_data_zero", out_data_o == '0, 1);
    check("mid_rst_rd_en", acc_rd_en_o, 0);
    check("mid_rst_busy", busy_o, 0);
    exp_q.delete();
    issued = 0;
    popped = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_start(ACC_RD_NORMAL, 7, 3, s);
    wait_done(200, 0, d);
    check("post_rst_latency", first_vld_cyc - s, 2);
    check("post_rst_beats", beats, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
